md_iter: RTL and testbench
==========================

MD_ITER -- requirements
Module: md_iter

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk  in  1  rising-edge clock; the block has one clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request for a new operation; sampled on the rising edge of clk.
REQ-005 op  in  2  operation code: 00 mult, 01 multu, 10 div, 11 divu; sampled with start.
REQ-006 a  in  32  operand rs (multiplicand or dividend); sampled with start.
REQ-007 b  in  32  operand rt (multiplier or divisor); sampled with start.
REQ-008 req  in  1  exception/interrupt flush; aborts any operation in flight.
REQ-009 busy  out  1  high while an operation is in flight; drives the downstream HI/LO stall logic.
REQ-010 done  out  1  one-cycle pulse meaning hi_out and lo_out hold a new result.
REQ-011 hi_out  out  32  high product word or remainder.
REQ-012 lo_out  out  32  low product word or quotient.

Function
REQ-013 The block shall implement a state machine with the states IDLE, RUN, FIX and DONE.
REQ-014 The block shall accept start only in IDLE or DONE and only when req=0; in every other state start shall be ignored.
REQ-015 On acceptance, the block shall latch op, |a| and |b| (magnitudes are taken for signed ops only) and clear its 6-bit iteration counter.
REQ-016 RUN shall last exactly 32 cycles, one radix-2 step per cycle.
REQ-017 Multiply step: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
REQ-018 Divide step: restoring shift-subtract on a 33-bit partial remainder, one quotient bit per cycle, MSB first.
REQ-019 FIX shall last one cycle and shall apply sign correction for signed ops.
- Product sign: a[31]^b[31].
- Quotient sign: a[31]^b[31].
- Remainder sign: a[31].
REQ-020 At the end of FIX, the block shall register the result into hi_out and lo_out and enter DONE.
REQ-021 busy shall be 1 in RUN and FIX and 0 in IDLE and DONE.
REQ-022 Timing of an accepted start at edge 0: busy=1 after edge 0; done=1 and busy=0 after edge 33.
REQ-023 done shall be 1 only in DONE, which lasts one cycle; DONE shall then go to IDLE, or to RUN if a new start is accepted.
REQ-024 hi_out and lo_out shall hold their value until the next completed operation.
REQ-025 Divide by zero (b=0, div or divu) shall give lo_out=32'hFFFFFFFF and hi_out=a, with no trap.
REQ-026 Signed overflow (div, a=32'h80000000, b=32'hFFFFFFFF) shall give lo_out=32'h80000000 and hi_out=0.
REQ-027 req=1 in any state shall move the block to IDLE at the next edge.
- busy and done shall be 0 after that edge.
- hi_out and lo_out shall be unchanged.
- A start in the same cycle as req shall be dropped.
REQ-028 If req=1 and FIX completion fall on the same edge, req shall win: no result is written and no done pulse is produced.

Reset
REQ-029 Reset shall force state=IDLE, busy=0, done=0, hi_out=0, lo_out=0 and counter=0, asynchronously.
REQ-030 Reset asserted mid-operation shall discard the operation with no done pulse.
REQ-031 After reset is released, the first accepted start shall behave per REQ-022.

Structure
REQ-032 The package md_pkg shall hold:
- the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
- the state enumeration;
- the constant MD_STEPS=32.
REQ-033 Sign correction shall be one combinational sub-module, md_signfix (inputs: magnitudes, op, a_sign, b_sign; outputs: hi, lo).
REQ-034 The remainder of the block shall be a single sequential process plus next-state logic, with no further sub-modules.

Verification
REQ-035 multu a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done exactly 34 edges after start.
REQ-036 mult a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; then div a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-037 divu a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-038 div a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-039 Abort after a prior result hi=1, lo=2:
- multu started, req pulsed at cycle 10 -> busy=0 the next cycle, no done, hi/lo remain 1/2;
- a start issued in the req cycle is ignored.
REQ-040 Back-to-back and reset cases:
- start asserted in the DONE cycle -> second result follows 34 edges later with no idle gap;
- reset at cycle 20 of a div -> all outputs 0 and no done.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and step count for the iterative mul/div unit.
package md_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_e;
  localparam int MD_STEPS = 32;
endpackage

// File: rtl/md_signfix.sv
// md_signfix: turns magnitude product/quotient/remainder into the final signed HI/LO pair.
module md_signfix
  import md_pkg::*;
(
  input  logic [31:0] hi_mag,
  input  logic [31:0] lo_mag,
  input  logic [31:0] dvsr,
  input  md_op_e      op,
  input  logic        a_sign,
  input  logic        b_sign,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic        neg;
  logic [63:0] prod;
  logic [63:0] sprod;
  assign neg   = a_sign ^ b_sign;
  assign prod  = {hi_mag, lo_mag};
  assign sprod = neg ? -prod : prod;
  // a zero divisor leaves the dividend as remainder; the quotient is pinned to all ones
  assign hi = op[1] ? (a_sign ? -hi_mag : hi_mag) : sprod[63:32];
  assign lo = op[1] ? ((dvsr == '0) ? '1 : (neg ? -lo_mag : lo_mag)) : sprod[31:0];
endmodule

// File: rtl/md_iter.sv
// md_iter: 32-cycle radix-2 multiply/divide unit with sign fix-up, abort and HI/LO result registers.
module md_iter
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  localparam logic [5:0] LAST = 6'(MD_STEPS - 1);
  md_state_e   state, state_n;
  md_op_e      op_q;
  logic [5:0]  cnt;
  logic [63:0] acc, mul_n, div_n;
  logic [31:0] mag, a_abs, b_abs, fix_hi, fix_lo;
  logic [32:0] sum, diff;
  logic        a_sgn, b_sgn, a_neg, b_neg, accept;
  assign accept = (state == IDLE || state == DONE) && start && !req;
  assign a_neg  = !op[0] && a[31];
  assign b_neg  = !op[0] && b[31];
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;
  // multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}
  assign sum   = {1'b0, acc[63:32]} + {1'b0, acc[0] ? mag : 32'd0};
  assign mul_n = {sum, acc[31:1]};
  assign diff  = acc[63:31] - {1'b0, mag};
  assign div_n = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
  assign busy  = state == RUN || state == FIX;
  assign done  = state == DONE;
  always_comb
    state_n = req ? IDLE :
              (state == RUN) ? ((cnt == LAST) ? FIX : RUN) :
              (state == FIX) ? DONE :
              accept ? RUN : IDLE;
  md_signfix u_signfix (
    .hi_mag(acc[63:32]),
    .lo_mag(acc[31:0]),
    .dvsr  (mag),
    .op    (op_q),
    .a_sign(a_sgn),
    .b_sign(b_sgn),
    .hi    (fix_hi),
    .lo    (fix_lo)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      op_q   <= MD_MULT;
      cnt    <= '0;
      acc    <= '0;
      mag    <= '0;
      a_sgn  <= 1'b0;
      b_sgn  <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= md_op_e'(op);
        a_sgn <= a_neg;
        b_sgn <= b_neg;
        mag   <= op[1] ? b_abs : a_abs;
        acc   <= {32'd0, op[1] ? a_abs : b_abs};
        cnt   <= '0;
      end else if (state == RUN) begin
        acc <= op_q[1] ? div_n : mul_n;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX && !req) begin
        hi_out <= fix_hi;
        lo_out <= fix_lo;
      end
    end
endmodule

// File: tb/tb_md_iter.sv
// tb_md_iter: directed vectors with a queue scoreboard checked whenever done pulses.
module tb_md_iter;
  import md_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;
  md_iter dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .req(req),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          id;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_chk = 0, n_fail = 0, id_n = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  always @(negedge clk)
    if (!reset && done) begin
      if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e_m = q.pop_front();
        chk($sformatf("hi[%0d]", e_m.id), {32'd0, hi_out}, {32'd0, e_m.hi});
        chk($sformatf("lo[%0d]", e_m.id), {32'd0, lo_out}, {32'd0, e_m.lo});
        chk($sformatf("latency[%0d]", e_m.id), 64'(cyc), 64'(e_m.cyc));
        chk($sformatf("busy_at_done[%0d]", e_m.id), {63'd0, busy}, 64'd0);
      end
    end
  // called at a negedge; start is accepted on the following rising edge
  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    op = o; a = x; b = y; start = 1'b1;
    if (push) q.push_back('{eh, el, cyc + 34, id_n});
    id_n++;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_q();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    drive(o, x, y, eh, el, 1'b1);
    wait_q();
  endtask
  initial begin
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run(MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run(MD_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
    run(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    run(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run(MD_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF);
    run(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1);
    repeat (3) @(negedge clk);
    chk("hold_hilo", {hi_out, lo_out}, {32'd0, 32'd1});
    // back-to-back: second start lands in the DONE cycle
    @(negedge clk);
    drive(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    drive(MD_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_q();
    // abort with req; a start in the same cycle is dropped
    run(MD_MULTU, 32'h80000001, 32'd2, 32'd1, 32'd2);
    @(negedge clk);
    drive(MD_MULTU, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    req = 1'b1; start = 1'b1; op = MD_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    req = 1'b0; start = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hilo", {hi_out, lo_out}, {32'd1, 32'd2});
    repeat (40) @(negedge clk);
    chk("abort_start_dropped", {63'd0, busy}, 64'd0);
    chk("abort_hilo_kept", {hi_out, lo_out}, {32'd1, 32'd2});
    // asynchronous reset mid-divide
    @(negedge clk);
    drive(MD_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (18) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    run(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
